// File: rtl/dram_read_pkg.sv
// Shared definitions for the DRAM AXI read master.
//   state_t        : controller states (IDLE / ADDR / DATA)
//   AXI_BURST_INCR : AXI incrementing burst encoding
//   AXI_RESP_OKAY  : AXI OKAY response encoding
//   BEAT_BYTES     : bytes carried by one read beat
//   BOUNDARY_BYTES : AXI bursts may not cross this address boundary
package dram_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BEAT_BYTES     = 16;
  localparam int         BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/dram_axi_read_master.sv
// DRAM AXI read master: turns a one-cycle read request (start address plus
// beat count) into one or two AXI INCR read bursts that never cross a 4 KB
// boundary, and streams the returned beats out with one cycle of latency.
//
// Ports:
//   m_axi_aclk, m_axi_reset      clock, synchronous active-high reset
//   dram_read_en/addr/len        request strobe, byte address, beats-1
//   dram_read_data/_data_valid   returned beat and qualifier (no backpressure)
//   dram_read_busy               request in progress
//   dram_read_error              sticky protocol/response error of last request
//   m_axi_ar*                    AXI read address channel
//   m_axi_r*                     AXI read data channel
//
// Build option: define DRAM_READ_TIMEOUT_EN to add a watchdog that abandons
// a request after TIMEOUT_CYCLES cycles without any AR or R handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request; dram_read_en accepted here only
// ST_ADDR | presenting one burst on AR, waiting for arready
// ST_DATA | accepting the beats of the current burst
module dram_axi_read_master
  import dram_read_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int M_AXI_ID_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_reset,
  input  logic                       dram_read_en,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_busy,
  output logic                       dram_read_error,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [M_AXI_ID_WIDTH-1:0]  m_axi_arid,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic [M_AXI_ID_WIDTH-1:0]  m_axi_rid,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_MASK = ~DRAM_ADDR_WIDTH'(BEAT_BYTES - 1);

  state_t                     state, state_nxt;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q;
  logic [8:0]                 remain_q;
  logic [8:0]                 beat_cnt_q;
  logic [12:0]                room_bytes;
  logic [8:0]                 room_beats;
  logic [8:0]                 burst_beats;
  logic                       accept, ar_hs, r_hs, last_beat, beat_bad, timeout;

  assign accept    = (state == ST_IDLE) && dram_read_en;
  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign last_beat = (beat_cnt_q == 9'd1);

  // Beats left before the next 4 KB boundary (1..256); addr_q[3:0] is always 0.
  assign room_bytes  = 13'(BOUNDARY_BYTES) - {1'b0, addr_q[11:0]};
  assign room_beats  = 9'(room_bytes / 13'(BEAT_BYTES));
  assign burst_beats = (remain_q < room_beats) ? remain_q : room_beats;

  // rlast is only checked against our own beat count, never trusted.
  assign beat_bad = (m_axi_rlast != last_beat) ||
                    (m_axi_rresp != AXI_RESP_OKAY) ||
                    (m_axi_rid != '0);

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(burst_beats - 9'd1);
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = '0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

`ifdef DRAM_READ_TIMEOUT_EN
  logic [31:0] wd_cnt_q;

  // Down-counter reloaded on every handshake; expiry is the terminal count
  // reached while still waiting in ADDR or DATA.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_reset) begin
      wd_cnt_q <= '0;
    end else if (accept || ar_hs || r_hs) begin
      wd_cnt_q <= 32'(TIMEOUT_CYCLES - 1);
    end else if (wd_cnt_q != '0) begin
      wd_cnt_q <= wd_cnt_q - 32'd1;
    end
  end

  assign timeout = (state != ST_IDLE) && !ar_hs && !r_hs && (wd_cnt_q == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dram_read_en) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (timeout)    state_nxt = ST_IDLE;
        else if (ar_hs) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        m_axi_rready = 1'b1;
        if (timeout)                 state_nxt = ST_IDLE;
        else if (r_hs && last_beat)  state_nxt = (remain_q == '0) ? ST_IDLE : ST_ADDR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_reset) begin
      addr_q               <= '0;
      remain_q             <= '0;
      beat_cnt_q           <= '0;
      dram_read_busy       <= 1'b0;
      dram_read_error      <= 1'b0;
      dram_read_data       <= '0;
      dram_read_data_valid <= 1'b0;
    end else begin
      dram_read_data_valid <= r_hs;
      if (r_hs) dram_read_data <= m_axi_rdata;

      // Busy drops one cycle after the final beat is presented: by then
      // the FSM has been in IDLE for exactly one cycle.
      if (accept) begin
        addr_q          <= dram_read_addr & BEAT_MASK;
        remain_q        <= {1'b0, dram_read_len} + 9'd1;
        dram_read_error <= 1'b0;
        dram_read_busy  <= 1'b1;
      end else if (state == ST_IDLE || timeout) begin
        dram_read_busy  <= 1'b0;
      end

      // After the first burst addr_q lands exactly on the next boundary.
      if (ar_hs) begin
        beat_cnt_q <= burst_beats;
        remain_q   <= remain_q - burst_beats;
        addr_q     <= addr_q + DRAM_ADDR_WIDTH'(burst_beats) * DRAM_ADDR_WIDTH'(BEAT_BYTES);
      end

      if (r_hs) begin
        beat_cnt_q <= beat_cnt_q - 9'd1;
        if (beat_bad) dram_read_error <= 1'b1;
      end

      if (timeout) dram_read_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_axi_read_master.sv
module tb_dram_axi_read_master;

  localparam int AW = 39;
  localparam int DW = 128;
  localparam int IW = 16;
`ifdef DRAM_READ_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_len = '0;
  logic [DW-1:0] dram_read_data;
  logic          dram_read_data_valid, dram_read_busy, dram_read_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [IW-1:0] m_axi_arid;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic [IW-1:0] m_axi_rid = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dram_axi_read_master #(
    .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .M_AXI_ID_WIDTH(IW), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .m_axi_aclk(clk), .m_axi_reset(rst),
    .dram_read_en(en), .dram_read_addr(req_addr), .dram_read_len(req_len),
    .dram_read_data(dram_read_data), .dram_read_data_valid(dram_read_data_valid),
    .dram_read_busy(dram_read_busy), .dram_read_error(dram_read_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [AW-1:0] a, input logic [31:0] s);
    return {s, a[31:0], s ^ 32'h5A5A_5A5A, 25'd0, a[38:32]};
  endfunction

  // slave / monitor state
  int            ar_mode = 0;    // 0 random, 1 always ready, 2 never ready
  int            rv_pct = 75;
  logic [31:0]   salt = '0;
  int            f_type = 0;     // 0 none, 1 SLVERR, 2 bad rid, 3 flipped rlast
  int            f_idx = 0;
  int            g_beat = 0;
  int            last_valid_cyc = 0;
  logic [AW-1:0] got_ar_addr[$];
  logic [7:0]    got_ar_len[$];
  logic [DW-1:0] got_data[$];
  bit            r_act = 0;
  logic [AW-1:0] r_addr = '0;
  int            r_beats = 0;
  int            r_idx = 0;
  bit            ar_wait = 0;
  logic [AW-1:0] ar_wait_addr = '0;
  logic [7:0]    ar_wait_len = '0;

  // Inputs change at negedge; DUT AXI outputs depend only on registered
  // state, so handshakes for the next posedge are known right here.
  always @(negedge clk) begin
    if (dram_read_data_valid) begin
      got_data.push_back(dram_read_data);
      last_valid_cyc = cyc;
    end
    if (rst) begin
      r_act = 0; ar_wait = 0;
      m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rlast = 1'b0;
    end else begin
      if (r_act && ($urandom_range(99) < rv_pct)) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_data(r_addr + AW'(16 * r_idx), salt);
        m_axi_rlast  = (r_idx == r_beats - 1) != (f_type == 3 && g_beat == f_idx);
        m_axi_rresp  = (f_type == 1 && g_beat == f_idx) ? 2'b10 : 2'b00;
        m_axi_rid    = (f_type == 2 && g_beat == f_idx) ? IW'(4) : '0;
        if (m_axi_rready) begin
          r_idx++; g_beat++;
          if (r_idx == r_beats) r_act = 0;
        end
      end else begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = '0; m_axi_rid = '0;
        m_axi_rdata = '0;
      end

      case (ar_mode)
        1:       m_axi_arready = 1'b1;
        2:       m_axi_arready = 1'b0;
        default: m_axi_arready = ($urandom_range(1) == 1);
      endcase
      if (m_axi_arvalid) begin
        chk("ar_r_overlap", m_axi_rready, 1'b0);
        if (ar_wait) chk("ar_stable", {m_axi_araddr, m_axi_arlen}, {ar_wait_addr, ar_wait_len});
        if (m_axi_arready) begin
          chk("ar_attr", {m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arcache, m_axi_arprot},
              {3'b100, 2'b01, 16'h0000, 4'b0011, 3'b000});
          got_ar_addr.push_back(m_axi_araddr);
          got_ar_len.push_back(m_axi_arlen);
          r_act = 1; r_addr = m_axi_araddr; r_beats = int'(m_axi_arlen) + 1; r_idx = 0;
          ar_wait = 0;
        end else begin
          ar_wait = 1; ar_wait_addr = m_axi_araddr; ar_wait_len = m_axi_arlen;
        end
      end else begin
        ar_wait = 0;
      end
    end
  end

  task automatic start_req(input logic [AW-1:0] addr, input logic [7:0] len,
                           input int ftype, input int fidx);
    f_type = ftype; f_idx = fidx; g_beat = 0;
    got_ar_addr.delete(); got_ar_len.delete(); got_data.delete();
    @(negedge clk);
    en = 1'b1; req_addr = addr; req_len = len;
    @(negedge clk);
    en = 1'b0;
    chk("busy_rise", dram_read_busy, 1'b1);
    chk("err_clear", dram_read_error, 1'b0);
    chk("arvalid_rise", m_axi_arvalid, 1'b1);
  endtask

  task automatic run_req(input logic [AW-1:0] addr, input logic [7:0] len,
                         input int ftype, input int fidx, input bit spurious);
    logic [AW-1:0] a;
    logic [AW-1:0] ea[$];
    logic [7:0]    el[$];
    logic [DW-1:0] ed[$];
    int n, room, b1, w;
    bit exp_err;
    salt = $urandom;
    a = addr & ~AW'(15);
    n = int'(len) + 1;
    room = (4096 - int'(a[11:0])) / 16;
    b1 = (n < room) ? n : room;
    ea.push_back(a); el.push_back(8'(b1 - 1));
    if (n > b1) begin
      ea.push_back(a + AW'(b1 * 16)); el.push_back(8'(n - b1 - 1));
    end
    for (int i = 0; i < n; i++) ed.push_back(beat_data(a + AW'(16 * i), salt));
    exp_err = (ftype >= 1 && ftype <= 3);

    start_req(addr, len, ftype, fidx);

    if (spurious) begin
      w = 0;
      while (got_data.size() == 0 && w < 2000) begin @(negedge clk); w++; end
      chk("first_beat_in_time", w < 2000, 1'b1);
      en = 1'b1; req_addr = AW'({$urandom, $urandom}); req_len = 8'($urandom);
      @(negedge clk);
      en = 1'b0;
    end

    w = 0;
    while (dram_read_busy && w < 4000) begin @(negedge clk); w++; end
    chk("done_in_time", w < 4000, 1'b1);
    chk("busy_fall", cyc - last_valid_cyc, 1);
    chk("ar_count", got_ar_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < got_ar_addr.size(); i++) begin
      chk("araddr", got_ar_addr[i], ea[i]);
      chk("arlen", got_ar_len[i], el[i]);
    end
    chk("beat_count", got_data.size(), n);
    for (int i = 0; i < n && i < got_data.size(); i++) chk("rdata", got_data[i], ed[i]);
    chk("error", dram_read_error, exp_err);
  endtask

  task automatic reset_test();
    int v, w;
    salt = $urandom;
    start_req(AW'('h3000), 8'd7, 0, 0);
    v = 0; w = 0;
    while (v < 2 && w < 2000) begin
      @(negedge clk); w++;
      if (dram_read_data_valid) v++;
    end
    chk("two_beats_in_time", w < 2000, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", dram_read_busy, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_valid", dram_read_data_valid, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_error", dram_read_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout reached at t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int ft;
    logic [7:0] ln;
    repeat (3) @(negedge clk);
    chk("reset_busy", dram_read_busy, 1'b0);
    chk("reset_error", dram_read_error, 1'b0);
    chk("reset_valid", dram_read_data_valid, 1'b0);
    chk("reset_arvalid", m_axi_arvalid, 1'b0);
    chk("reset_rready", m_axi_rready, 1'b0);
    chk("reset_data", dram_read_data, '0);
    chk("reset_araddr", m_axi_araddr, '0);
    rst = 1'b0;
    @(negedge clk);

    ar_mode = 1; rv_pct = 100;
    run_req(AW'('h1000), 8'd15, 0, 0, 0);
    ar_mode = 0; rv_pct = 75;
    run_req(AW'('h1F80), 8'd15, 0, 0, 0);
    run_req(AW'('h5000), 8'd31, 0, 0, 1);
    run_req(AW'('h6000), 8'd7, 1, 2, 0);
    run_req(AW'('h6100), 8'd7, 0, 0, 0);
    run_req(AW'('h7FF0), 8'd255, 3, 0, 0);
    run_req(AW'('h8000), 8'd255, 2, 255, 0);
    reset_test();
    run_req(AW'('h0FFF), 8'd0, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      ar_mode = $urandom_range(1);
      rv_pct = $urandom_range(100, 40);
      ln = 8'($urandom);
      ft = ($urandom_range(99) < 30) ? $urandom_range(3, 1) : 0;
      run_req(AW'({$urandom, $urandom}), ln, ft, $urandom_range(int'(ln)), ($urandom_range(3) == 0) && ln > 3);
    end

`ifdef DRAM_READ_TIMEOUT_EN
    begin
      int hi;
      ar_mode = 2;
      start_req(AW'('h9000), 8'd3, 0, 0);
      hi = 1;
      @(negedge clk);
      while (dram_read_busy && hi < 1000) begin hi++; @(negedge clk); end
      chk("timeout_cycles", hi, TO_CYC);
      chk("timeout_error", dram_read_error, 1'b1);
      chk("timeout_busy", dram_read_busy, 1'b0);
      chk("timeout_arvalid", m_axi_arvalid, 1'b0);
      ar_mode = 0;
      run_req(AW'('hA000), 8'd5, 0, 0, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
